// File: rtl/string_pkg.sv
// -----------------------------------------------------------------------------
// string_pkg
// Shared definitions for the WS2812B-format string decoder and string driver.
// Contents:
//   state_t    - line-tracking FSM states (SYNC, BLANK, HIGH, LOW)
//   *_NS       - nominal line timings in nanoseconds
//   get_count  - converts a duration in ns to a clock count, rounding up
// -----------------------------------------------------------------------------
package string_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_BLANK = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  // Nominal WS2812B bit timings.
  localparam int T0H_NS = 400;
  localparam int T1H_NS = 800;
  localparam int T0L_NS = 850;
  localparam int T1L_NS = 450;
  // Blank period a driver emits between frames.
  localparam int T_BLANK_NS = 50000;
  // Decoder limits: bit threshold, longest legal high, shortest blank.
  localparam int T_THRESH_NS   = 600;
  localparam int T_MAX_HIGH_NS = 2000;
  localparam int T_RESET_NS    = 40000;

  // Number of whole clock periods needed to cover t_ns (ceil division).
  function automatic int get_count(input int t_ns, input int period_ns);
    return (t_ns + period_ns - 1) / period_ns;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for a single asynchronous input bit.
// Parameters:
//   RESET_VAL - value both flops take while rst is high
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   i_d  in  asynchronous input
//   o_q  out synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/string_decoder.sv
// -----------------------------------------------------------------------------
// string_decoder
// Decodes a WS2812B-format serial line into 24-bit pixels by measuring the
// length of each high pulse with a single run-length counter.
// Parameters:
//   CLK_PERIOD_NS - clock period in ns; all timing counts derive from it
// Ports:
//   clk              in  system clock, rising edge
//   rst              in  synchronous active-high reset
//   sdi              in  serial line, asynchronous to clk, idles high
//   pixel_data       out last decoded pixel (first bit on the line is MSB)
//   pixel_data_valid out one-cycle pulse when pixel_data updates
//   h_blank          out one-cycle pulse per detected blank (long low)
//   err              out one-cycle pulse on protocol error
//   sdo              out regenerated downstream line (STRING_DECODER_FWD_EN only)
// Build option:
//   STRING_DECODER_FWD_EN - decode only the first pixel after each blank and
//   forward the rest of the frame on sdo.
// -----------------------------------------------------------------------------
module string_decoder
  import string_pkg::*;
#(
  parameter int CLK_PERIOD_NS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdi,
  output logic [23:0] pixel_data,
  output logic        pixel_data_valid,
  output logic        h_blank,
  output logic        err
`ifdef STRING_DECODER_FWD_EN
  ,
  output logic        sdo
`endif
);

  localparam logic [15:0] K_THRESH   = 16'(get_count(T_THRESH_NS, CLK_PERIOD_NS));
  localparam logic [15:0] K_MAX_HIGH = 16'(get_count(T_MAX_HIGH_NS, CLK_PERIOD_NS));
  localparam logic [15:0] K_RESET    = 16'(get_count(T_RESET_NS, CLK_PERIOD_NS));

  logic        w_sdi_s;
  logic        r_sdi_d;
  logic        w_edge;
  logic        w_rise;
  logic        w_fall;
  logic [15:0] w_len;
  logic        w_bit;
  logic        w_hi_to;
  logic        w_lo_to;
  logic        w_decode;
  logic [23:0] w_shift_next;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [4:0]  r_bits;
  logic [23:0] r_shift;
  logic [23:0] r_pixel;
  logic        r_valid;
  logic        r_blank;
  logic        r_err;

  bit_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (sdi),
    .o_q (w_sdi_s)
  );

  assign w_edge = w_sdi_s ^ r_sdi_d;
  assign w_rise = w_edge & w_sdi_s;
  assign w_fall = w_edge & ~w_sdi_s;

  // r_cnt is cleared on the edge cycle, so the run just completed (or the run
  // in progress, counted up to the previous cycle) is r_cnt + 1.
  assign w_len   = r_cnt + 16'd1;
  assign w_bit   = (w_len >= K_THRESH);
  assign w_hi_to = (w_len >= K_MAX_HIGH);
  // A blank is only recognised when no edge arrives in the same cycle.
  assign w_lo_to = ~w_edge & ~w_sdi_s & (w_len >= K_RESET);

  assign w_shift_next = {r_shift[22:0], w_bit};

`ifdef STRING_DECODER_FWD_EN
  logic r_done;   // first pixel after the blank has been consumed
  logic r_fwd;    // line is being regenerated on sdo
  logic r_sdo;

  assign w_decode = ~r_done;
  assign sdo      = r_sdo;

  // Forwarding starts on the rising edge that follows the consumed pixel, so
  // the tail low of its last bit is swallowed rather than passed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdo <= 1'b1;
    end else begin
      r_sdo <= r_fwd ? w_sdi_s : 1'b1;
    end
  end
`else
  assign w_decode = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdi_d <= 1'b1;
      r_cnt   <= 16'd0;
    end else begin
      r_sdi_d <= w_sdi_s;
      if (w_edge) begin
        r_cnt <= 16'd0;
      end else if (r_cnt != K_RESET) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SYNC;
      r_bits  <= 5'd0;
      r_shift <= 24'd0;
      r_pixel <= 24'd0;
      r_valid <= 1'b0;
      r_blank <= 1'b0;
      r_err   <= 1'b0;
`ifdef STRING_DECODER_FWD_EN
      r_done  <= 1'b0;
      r_fwd   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_blank <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_SYNC: begin
          if (w_lo_to) begin
            r_state <= ST_BLANK;
            r_blank <= 1'b1;
          end
        end
        ST_BLANK: begin
          if (w_rise) begin
            r_state <= ST_HIGH;
`ifdef STRING_DECODER_FWD_EN
            r_done  <= 1'b0;
            r_fwd   <= 1'b0;
`endif
          end
        end
        ST_HIGH: begin
          if (w_hi_to) begin
            // Stuck-high line: drop the partial pixel and resynchronise.
            r_state <= ST_SYNC;
            r_err   <= 1'b1;
            r_bits  <= 5'd0;
            r_shift <= 24'd0;
          end else if (w_fall) begin
            r_state <= ST_LOW;
            if (w_decode) begin
              r_shift <= w_shift_next;
              if (r_bits == 5'd23) begin
                r_pixel <= w_shift_next;
                r_valid <= 1'b1;
                r_bits  <= 5'd0;
`ifdef STRING_DECODER_FWD_EN
                r_done  <= 1'b1;
`endif
              end else begin
                r_bits <= r_bits + 5'd1;
              end
            end
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_state <= ST_HIGH;
`ifdef STRING_DECODER_FWD_EN
            if (r_done) begin
              r_fwd <= 1'b1;
            end
`endif
          end else if (w_lo_to) begin
            r_state <= ST_BLANK;
            r_blank <= 1'b1;
            r_err   <= (r_bits != 5'd0);
            r_bits  <= 5'd0;
            r_shift <= 24'd0;
          end
        end
        default: begin
          r_state <= ST_SYNC;
        end
      endcase
    end
  end

  assign pixel_data       = r_pixel;
  assign pixel_data_valid = r_valid;
  assign h_blank          = r_blank;
  assign err              = r_err;

endmodule

// File: tb/tb_string_decoder.sv
// -----------------------------------------------------------------------------
// tb_string_decoder
// Self-checking bench for string_decoder. Expected pixels are queued when a
// full pixel is driven and compared when pixel_data_valid pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_string_decoder;

  localparam int CLK_NS = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdi;
  logic [23:0] pixel_data;
  logic        pixel_data_valid;
  logic        h_blank;
  logic        err;
`ifdef STRING_DECODER_FWD_EN
  logic        sdo;
`endif

  string_decoder #(
    .CLK_PERIOD_NS (CLK_NS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sdi              (sdi),
    .pixel_data       (pixel_data),
    .pixel_data_valid (pixel_data_valid),
    .h_blank          (h_blank),
    .err              (err)
`ifdef STRING_DECODER_FWD_EN
    ,
    .sdo              (sdo)
`endif
  );

  always #(CLK_NS / 2) clk = ~clk;

  int          cyc = 0;
  int          last_fall = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_valid = 0;
  int          n_blank = 0;
  int          n_err = 0;
  int          n_both = 0;
  int          fwd_mode = 0;
  logic [2:0]  sdi_hist = 3'b111;
  logic [23:0] exp_q[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    sdi_hist <= {sdi_hist[1:0], sdi};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: one line per decoded pixel.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (pixel_data_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("valid_unexpected", 32'(pixel_data_valid), 32'd0);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          $display("pixel %06h expected %06h latency %0d", pixel_data, e, cyc - last_fall);
          check("pixel", 32'(pixel_data), 32'(e));
          check("valid_latency", 32'(cyc - last_fall), 32'd3);
        end
      end
      if (h_blank) n_blank++;
      if (err) n_err++;
      if (h_blank && err) n_both++;
`ifdef STRING_DECODER_FWD_EN
      if (fwd_mode == 1) check("sdo_hold", 32'(sdo), 32'd1);
      if (fwd_mode == 2) check("sdo_fwd", 32'(sdo), 32'(sdi_hist[2]));
`endif
    end
  end

  // Drive level v for n cycles; called from negedge context.
  task automatic drive(input logic v, input int n);
    if (sdi === 1'b1 && v == 1'b0) last_fall = cyc;
    sdi = v;
    repeat (n) @(negedge clk);
  endtask

  // Send the top nbits of px; bit index ext_idx gets a low of ext_lo cycles.
  task automatic send_bits(input logic [23:0] px, input int nbits,
                           input int hi1, input int lo1, input int hi0, input int lo0,
                           input int ext_idx, input int ext_lo, input bit expect_px);
    if (expect_px && nbits == 24) exp_q.push_back(px);
    for (int i = 23; i > 23 - nbits; i--) begin
      drive(1'b1, px[i] ? hi1 : hi0);
      drive(1'b0, (i == ext_idx) ? ext_lo : (px[i] ? lo1 : lo0));
    end
  endtask

  task automatic send_pixel(input logic [23:0] px, input bit expect_px);
    send_bits(px, 24, 8, 5, 4, 9, -1, 0, expect_px);
  endtask

  int b0, e0, v0, x0;

  initial begin
    rst = 1'b1;
    sdi = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_pixel", 32'(pixel_data), 32'd0);
    check("rst_valid", 32'(pixel_data_valid), 32'd0);
    check("rst_blank", 32'(h_blank), 32'd0);
    check("rst_err", 32'(err), 32'd0);
`ifdef STRING_DECODER_FWD_EN
    check("rst_sdo", 32'(sdo), 32'd1);
`endif
    rst = 1'b0;
    repeat (5) @(negedge clk);

`ifndef STRING_DECODER_FWD_EN
    // Single blank after reset.
    b0 = n_blank; e0 = n_err;
    drive(1'b0, 420);
    $display("blank after reset: h_blank %0d err %0d", n_blank - b0, n_err - e0);
    check("blank_once", 32'(n_blank - b0), 32'd1);
    check("blank_no_err", 32'(n_err - e0), 32'd0);

    // Nominal pixel, then threshold-boundary widths (6H -> 1, 5H -> 0).
    send_pixel(24'hA5C30F, 1'b1);
    send_bits(24'h3C5A96, 24, 6, 7, 5, 8, -1, 0, 1'b1);
    drive(1'b0, 10);

    // 12 bits then blank: err with h_blank, partial pixel dropped.
    b0 = n_blank; e0 = n_err; v0 = n_valid; x0 = n_both;
    send_bits(24'hFFF000, 12, 8, 5, 4, 9, -1, 0, 1'b0);
    drive(1'b0, 420);
    $display("partial blank: h_blank %0d err %0d together %0d", n_blank - b0, n_err - e0, n_both - x0);
    check("partial_blank", 32'(n_blank - b0), 32'd1);
    check("partial_err", 32'(n_err - e0), 32'd1);
    check("partial_same_cycle", 32'(n_both - x0), 32'd1);
    check("partial_no_valid", 32'(n_valid - v0), 32'd0);
    send_pixel(24'h00FF00, 1'b1);
    drive(1'b0, 10);

    // Stuck-high mid-pixel: err, then ignored until the next blank.
    send_bits(24'hC0FFEE, 10, 8, 5, 4, 9, -1, 0, 1'b0);
    e0 = n_err; v0 = n_valid;
    drive(1'b1, 25);
    drive(1'b0, 9);
    check("maxhigh_err", 32'(n_err - e0), 32'd1);
    send_pixel(24'h111111, 1'b0);
    $display("after stuck high: err %0d valid %0d", n_err - e0, n_valid - v0);
    check("sync_no_valid", 32'(n_valid - v0), 32'd0);
    b0 = n_blank; e0 = n_err;
    drive(1'b0, 420);
    check("sync_blank", 32'(n_blank - b0), 32'd1);
    check("sync_blank_no_err", 32'(n_err - e0), 32'd0);
    send_pixel(24'hDEAD01, 1'b1);

    // Low of exactly 400 cycles ending in a rising edge: edge wins.
    b0 = n_blank; e0 = n_err;
    send_bits(24'hABCDEF, 24, 8, 5, 4, 9, 12, 400, 1'b1);
    drive(1'b0, 10);
    $display("edge vs blank: h_blank %0d err %0d", n_blank - b0, n_err - e0);
    check("edge_wins_blank", 32'(n_blank - b0), 32'd0);
    check("edge_wins_err", 32'(n_err - e0), 32'd0);
    check("valid_total", 32'(n_valid), 32'd5);
`else
    // Forwarding: first pixel decoded, second regenerated on sdo.
    drive(1'b0, 420);
    fwd_mode = 1;
    send_pixel(24'h123456, 1'b1);
    sdi = 1'b1;                       // bit 23 of 0x654321 is 0: 4H/9L
    repeat (3) @(negedge clk);
    fwd_mode = 2;
    @(negedge clk);
    drive(1'b0, 9);
    send_bits(24'h654321, 23, 8, 5, 4, 9, -1, 0, 1'b0);
    drive(1'b0, 420);
    fwd_mode = 0;
    drive(1'b1, 1);
    drive(1'b0, 10);
    check("fwd_valid_total", 32'(n_valid), 32'd1);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
